// File: rtl/acc_pixel_map.sv
// acc_pixel_map: streams an image from word-addressed memory, applies a
// per-pixel mapping to every lane of each word, and writes the results to a
// separate output region using the start/finish memory-port protocol.
//
// Ports:
//   clk     system clock, rising edge
//   reset   asynchronous active-low reset
//   start   level request to process one image
//   mode    mapping select (0 copy, 1 invert, 2 threshold, 3 in-word mirror),
//           latched when start is accepted
//   addr    memory address
//   dataR   memory read data, valid the cycle after a read request
//   dataW   memory write data
//   en      memory access enable
//   we      memory write enable (meaningful with en=1)
//   busy    high while reading/writing the image
//   finish  image complete; held until start drops
module acc_pixel_map #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned PIX_W      = 8,
  parameter int unsigned IMG_WORDS  = 25344,
  parameter int unsigned OUT_OFFSET = 25344,
  parameter int unsigned THRESH     = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  output logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] dataR,
  output logic [DATA_W-1:0] dataW,
  output logic              en,
  output logic              we,
  output logic              busy,
  output logic              finish
);

  localparam int unsigned LANES = DATA_W / PIX_W;

  if ((DATA_W % PIX_W) != 0) begin : g_bad_lanes
    $error("acc_pixel_map: DATA_W must be a multiple of PIX_W");
  end
  if (IMG_WORDS == 0) begin : g_bad_size
    $error("acc_pixel_map: IMG_WORDS must be non-zero");
  end

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(IMG_WORDS - 1);
  localparam logic [ADDR_W-1:0] OUT_BASE = ADDR_W'(OUT_OFFSET);
  // Threshold compared in a widened domain so a THRESH above the pixel range
  // simply never matches instead of wrapping.
  localparam logic [PIX_W+31:0] THR_W   = (PIX_W + 32)'(THRESH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] idx;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] mapped;
  logic [PIX_W-1:0]  lane_p;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      idx    <= '0;
      mode_q <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (start) begin
          mode_q <= mode;
          idx    <= '0;
        end
        WRITE: if (idx != LAST_IDX) idx <= idx + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = READ;
      READ:    state_n = WRITE;
      WRITE:   state_n = (idx == LAST_IDX) ? DONE : READ;
      DONE:    if (!start) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Per-lane mapping, combinational from the word read in the previous cycle.
  always_comb begin
    mapped = '0;
    lane_p = '0;
    for (int unsigned j = 0; j < LANES; j++) begin
      lane_p = dataR[j*PIX_W +: PIX_W];
      case (mode_q)
        2'd0: mapped[j*PIX_W +: PIX_W] = lane_p;
        2'd1: mapped[j*PIX_W +: PIX_W] = ~lane_p;
        2'd2: mapped[j*PIX_W +: PIX_W] =
                ((PIX_W + 32)'(lane_p) >= THR_W) ? '1 : '0;
        default: mapped[j*PIX_W +: PIX_W] = dataR[(LANES-1-j)*PIX_W +: PIX_W];
      endcase
    end
  end

  // Moore outputs decoded from registered state/idx/mode.
  always_comb begin
    addr   = '0;
    dataW  = '0;
    en     = 1'b0;
    we     = 1'b0;
    busy   = 1'b0;
    finish = 1'b0;
    case (state)
      READ: begin
        en   = 1'b1;
        addr = idx;
        busy = 1'b1;
      end
      WRITE: begin
        en    = 1'b1;
        we    = 1'b1;
        addr  = OUT_BASE + idx;
        dataW = mapped;
        busy  = 1'b1;
      end
      DONE:    finish = 1'b1;
      default: ;
    endcase
  end

endmodule
